reg_ref_table: RTL



---
 rtl/reg_ref_table_pkg.sv | 20 ++
 rtl/reg_ref_table_bypass.sv | 82 ++++++++
 rtl/reg_ref_table.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reg_ref_table_pkg.sv
// Shared definitions for the register reference table.
// Holds the default widths, the architectural zero register constant and the
// helper that maps (channel, slot) to a flat operand-slot index.
package reg_ref_table_pkg;

  localparam int unsigned REF_WIDTH      = 2;
  localparam int unsigned REF_REG_NUM    = 32;
  localparam int unsigned REF_RA         = $clog2(REF_REG_NUM);
  localparam int unsigned REF_TAG_WIDTH  = 4;
  localparam int unsigned REF_DATA_WIDTH = 32;

  // Architectural register 0 reads as zero and is never renamed.
  localparam int unsigned REG_ZERO = 0;

  // Operand slot index: channel c, source slot s (0 or 1).
  function automatic int unsigned slot_idx(input int unsigned c, input int unsigned s);
    return c * 2 + s;
  endfunction

endpackage

// File: rtl/reg_ref_table_bypass.sv
// ref_bypass_mux: resolves one source operand into a value or a ROB-tag
// reference. Priority, first match wins:
//   1. register 0            -> value 0
//   2. in-group bypass       -> newest tag written by a lower channel this cycle
//   3. commit bypass         -> committed value (REF_COMMIT_BYPASS_EN only)
//   4. table busy            -> stored tag
//   5. otherwise             -> regfile value
// Ports:
//   addr_i        source register address
//   rf_data_i     committed regfile value for addr_i
//   wr_en_i/wr_addr_i/wr_tag_i   rename writes of the whole group (packed per channel)
//   busy_i/tag_i  table entry for addr_i
//   commit_*_i    ROB commit port
//   is_ref_o/data_o  resolved operand (data_o holds the zero-extended tag when is_ref_o=1)
// Optional feature macro: REF_COMMIT_BYPASS_EN enables rule 3.
import reg_ref_table_pkg::*;

module ref_bypass_mux #(
  parameter int unsigned WIDTH      = REF_WIDTH,
  parameter int unsigned RA         = REF_RA,
  parameter int unsigned TAG_WIDTH  = REF_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = REF_DATA_WIDTH,
  parameter int unsigned CH         = 0
) (
  input  logic [RA-1:0]              addr_i,
  input  logic [DATA_WIDTH-1:0]      rf_data_i,
  input  logic [WIDTH-1:0]           wr_en_i,
  input  logic [WIDTH*RA-1:0]        wr_addr_i,
  input  logic [WIDTH*TAG_WIDTH-1:0] wr_tag_i,
  input  logic                       busy_i,
  input  logic [TAG_WIDTH-1:0]       tag_i,
  input  logic                       commit_en_i,
  input  logic [RA-1:0]              commit_addr_i,
  input  logic [TAG_WIDTH-1:0]       commit_tag_i,
  input  logic [DATA_WIDTH-1:0]      commit_data_i,
  output logic                       is_ref_o,
  output logic [DATA_WIDTH-1:0]      data_o
);

  logic                 hit;
  logic [TAG_WIDTH-1:0] hit_tag;
  logic                 commit_hit;

`ifdef REF_COMMIT_BYPASS_EN
  assign commit_hit = busy_i && commit_en_i && (commit_addr_i == addr_i) &&
                      (commit_tag_i == tag_i);
`else
  logic unused_commit;
  assign unused_commit = ^{commit_en_i, commit_addr_i, commit_tag_i, commit_data_i};
  assign commit_hit    = 1'b0;
`endif

  // Only channels below this one are older in program order; scanning upward
  // lets the highest matching channel win.
  always_comb begin
    hit     = 1'b0;
    hit_tag = '0;
    for (int j = 0; j < int'(WIDTH); j++) begin
      if ((j < int'(CH)) && wr_en_i[j] && (wr_addr_i[j*RA +: RA] == addr_i)) begin
        hit     = 1'b1;
        hit_tag = wr_tag_i[j*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  always_comb begin
    is_ref_o = 1'b0;
    data_o   = rf_data_i;
    if (addr_i == RA'(REG_ZERO)) begin
      data_o = '0;
    end else if (hit) begin
      is_ref_o = 1'b1;
      data_o   = DATA_WIDTH'(hit_tag);
    end else if (commit_hit) begin
      data_o = commit_data_i;
    end else if (busy_i) begin
      is_ref_o = 1'b1;
      data_o   = DATA_WIDTH'(tag_i);
    end
  end

endmodule

// File: rtl/reg_ref_table.sv
// reg_ref_table: per-architectural-register busy/ROB-tag table for the ID
// stage, resolving WIDTH instructions (two sources each) per cycle.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   flush          clears every busy bit; writes and commit ignored that cycle
//   stall          rename writes ignored (lookups still see the group bypass)
//   rd_addr/rf_data  source addresses and regfile values, slot c*2+s
//   wr_en/wr_addr/wr_tag  rename destination per channel
//   commit_*       ROB commit port
//   op_is_ref/op_data  resolved operands, slot c*2+s
//   busy_count     registered number of busy registers
// Optional feature macro: REF_COMMIT_BYPASS_EN (same-cycle commit bypass on
// lookups; the table update is identical in both builds).
import reg_ref_table_pkg::*;

module reg_ref_table #(
  parameter int unsigned WIDTH      = REF_WIDTH,
  parameter int unsigned REG_NUM    = REF_REG_NUM,
  parameter int unsigned TAG_WIDTH  = REF_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = REF_DATA_WIDTH,
  localparam int unsigned RA        = $clog2(REG_NUM),
  localparam int unsigned CW        = $clog2(REG_NUM) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          stall,
  input  logic [WIDTH*2*RA-1:0]         rd_addr,
  input  logic [WIDTH*2*DATA_WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0]              wr_en,
  input  logic [WIDTH*RA-1:0]           wr_addr,
  input  logic [WIDTH*TAG_WIDTH-1:0]    wr_tag,
  input  logic                          commit_en,
  input  logic [RA-1:0]                 commit_addr,
  input  logic [TAG_WIDTH-1:0]          commit_tag,
  input  logic [DATA_WIDTH-1:0]         commit_data,
  output logic [WIDTH*2-1:0]            op_is_ref,
  output logic [WIDTH*2*DATA_WIDTH-1:0] op_data,
  output logic [CW-1:0]                 busy_count
);

  logic [REG_NUM-1:0]                busy_q, busy_d;
  logic [REG_NUM-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CW-1:0]                     count_q, count_d;

  // Next-state: commit clears first, then rename sets, so a same-cycle rename
  // of the committed register wins.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      // A tag mismatch means the register was renamed again after this
      // producer; the newer mapping must stay busy.
      if (commit_en && busy_q[commit_addr] && (tag_q[commit_addr] == commit_tag)) begin
        busy_d[commit_addr] = 1'b0;
      end
      if (!stall) begin
        for (int c = 0; c < int'(WIDTH); c++) begin
          if (wr_en[c] && (wr_addr[c*RA +: RA] != RA'(REG_ZERO))) begin
            busy_d[wr_addr[c*RA +: RA]] = 1'b1;
            tag_d[wr_addr[c*RA +: RA]]  = wr_tag[c*TAG_WIDTH +: TAG_WIDTH];
          end
        end
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      count_d = count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      tag_q   <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

  for (genvar c = 0; c < int'(WIDTH); c++) begin : g_ch
    for (genvar s = 0; s < 2; s++) begin : g_slot
      localparam int unsigned K = slot_idx(c, s);
      logic [RA-1:0]         addr;
      logic                  is_ref;
      logic [DATA_WIDTH-1:0] data;

      assign addr = rd_addr[K*RA +: RA];

      ref_bypass_mux #(
        .WIDTH      (WIDTH),
        .RA         (RA),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CH         (c)
      ) u_mux (
        .addr_i        (addr),
        .rf_data_i     (rf_data[K*DATA_WIDTH +: DATA_WIDTH]),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_tag_i      (wr_tag),
        .busy_i        (busy_q[addr]),
        .tag_i         (tag_q[addr]),
        .commit_en_i   (commit_en),
        .commit_addr_i (commit_addr),
        .commit_tag_i  (commit_tag),
        .commit_data_i (commit_data),
        .is_ref_o      (is_ref),
        .data_o        (data)
      );

      // Operands are forced to zero while reset is held.
      assign op_is_ref[K]                       = rst ? is_ref : 1'b0;
      assign op_data[K*DATA_WIDTH +: DATA_WIDTH] = rst ? data : '0;
    end
  end

endmodule
